// File: rtl/ahb_timer_pkg.sv
// Shared constants and types for the AHB-Lite timer: register word offsets,
// CTRL bit layout and HTRANS encodings.
package ahb_timer_pkg;

  localparam logic [2:0] OFF_CTRL     = 3'd0;
  localparam logic [2:0] OFF_LOAD     = 3'd1;
  localparam logic [2:0] OFF_VALUE    = 3'd2;
  localparam logic [2:0] OFF_STATUS   = 3'd3;
  localparam logic [2:0] OFF_PRESCALE = 3'd4;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_IE   = 1;
  localparam int CTRL_MODE = 2;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // Field order matches the CTRL bit indices above (mode is the MSB).
  typedef struct packed {
    logic mode;
    logic ie;
    logic en;
  } ctrl_t;

endpackage

// File: rtl/ahb_timer_prescaler.sv
// Free-running 8-bit prescaler: emits a one-cycle tick every prescale+1
// enabled cycles; held at zero while disabled or on restart.
module timer_prescaler (
  input  logic       clk,
  input  logic       RSTn,
  input  logic       en,
  input  logic       restart,
  input  logic [7:0] prescale,
  output logic       tick
);

  logic [7:0] pcnt;

  assign tick = en && (pcnt == prescale);

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      pcnt <= '0;
    end else if (!en || restart || tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 8'd1;
    end
  end

endmodule

// File: rtl/ahb_timer.sv
// Zero-wait-state AHB-Lite slave wrapping a 32-bit down-counting timer with
// prescaler, periodic/one-shot modes and a level interrupt.
module ahb_timer
  import ahb_timer_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              RSTn,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic [2:0]        HSIZE,
  input  logic              HWRITE,
  input  logic [31:0]       HWDATA,
  input  logic              HREADY,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [31:0]       HRDATA,
  output logic              IRQ
);

  logic        dp_valid;
  logic        dp_write;
  logic [2:0]  dp_off;
  ctrl_t       ctrl;
  logic [31:0] load;
  logic [31:0] value;
  logic        flag;
  logic [7:0]  prescale;
  logic        tick;
  logic        expire;
  logic [31:0] rdata;

  logic addr_accept;
  logic wr_en, wr_ctrl, wr_load, wr_status, wr_prescale;
  logic restart;

  assign addr_accept = HSEL && HREADY &&
                       ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_off   <= '0;
    end else begin
      dp_valid <= addr_accept;
      dp_write <= HWRITE;
      dp_off   <= HADDR[4:2];
    end
  end

  assign wr_en       = dp_valid && dp_write;
  assign wr_ctrl     = wr_en && (dp_off == OFF_CTRL);
  assign wr_load     = wr_en && (dp_off == OFF_LOAD);
  assign wr_status   = wr_en && (dp_off == OFF_STATUS);
  assign wr_prescale = wr_en && (dp_off == OFF_PRESCALE);
  assign restart     = wr_ctrl && HWDATA[CTRL_EN] && !ctrl.en;

  timer_prescaler u_prescaler (
    .clk      (clk),
    .RSTn     (RSTn),
    .en       (ctrl.en),
    .restart  (restart),
    .prescale (prescale),
    .tick     (tick)
  );

  assign expire = tick && (value == '0);

  // NOTE: non-blocking updates let later assignments in this block override
  // earlier ones on the same edge, so bus writes are placed last to win races.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      ctrl     <= '0;
      load     <= '0;
      value    <= '0;
      flag     <= 1'b0;
      prescale <= '0;
    end else begin
      if (tick) begin
        if (value != '0) begin
          value <= value - 32'd1;
        end else if (ctrl.mode) begin
          ctrl.en <= 1'b0;
        end else begin
          value <= load;
        end
      end
      if (wr_load) begin
        load  <= HWDATA;
        value <= HWDATA;
      end
      if (wr_ctrl) begin
        ctrl <= ctrl_t'(HWDATA[CTRL_MODE:CTRL_EN]);
      end
      if (wr_prescale) begin
        prescale <= HWDATA[7:0];
      end
      // A hardware set in the same cycle as a W1C keeps the flag asserted.
      flag <= expire || (flag && !(wr_status && HWDATA[0]));
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rdata = '0;
    case (dp_off)
      OFF_CTRL:     rdata = {29'd0, ctrl};
      OFF_LOAD:     rdata = load;
      OFF_VALUE:    rdata = value;
      OFF_STATUS:   rdata = {31'd0, flag};
      OFF_PRESCALE: rdata = {24'd0, prescale};
      default:      rdata = '0;
    endcase
  end

  assign HRDATA    = (dp_valid && !dp_write) ? rdata : 32'd0;
  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign IRQ       = flag && ctrl.ie;

  logic unused;
  assign unused = ^{HSIZE, HADDR[ADDR_W-1:5], HADDR[1:0]};

endmodule

// File: tb/tb_ahb_timer.sv
// Scoreboard bench for ahb_timer: bus tasks queue expected read data, a
// monitor pops and compares in every read data phase.
`timescale 1ns/1ps
module tb_ahb_timer;

  logic        clk = 1'b0;
  logic        RSTn = 1'b0;
  logic        HSEL = 1'b0;
  logic [11:0] HADDR = '0;
  logic [1:0]  HTRANS = 2'b00;
  logic [2:0]  HSIZE = 3'b010;
  logic        HWRITE = 1'b0;
  logic [31:0] HWDATA = '0;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;
  logic        IRQ;

  localparam logic [11:0] A_CTRL = 12'h000, A_LOAD = 12'h004, A_VALUE = 12'h008,
                          A_STATUS = 12'h00C, A_PRESCALE = 12'h010, A_UNMAPPED = 12'h014;

  always #5 clk = ~clk;
  assign HREADY = HREADYOUT;

  ahb_timer #(.ADDR_W(12)) dut (
    .clk       (clk),
    .RSTn      (RSTn),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HSIZE     (HSIZE),
    .HWRITE    (HWRITE),
    .HWDATA    (HWDATA),
    .HREADY    (HREADY),
    .HREADYOUT (HREADYOUT),
    .HRESP     (HRESP),
    .HRDATA    (HRDATA),
    .IRQ       (IRQ)
  );

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic start(input logic wr, input logic [11:0] a);
    HSEL = 1'b1;
    HTRANS = 2'b10;
    HWRITE = wr;
    HADDR = a;
  endtask

  task automatic go_idle();
    HSEL = 1'b0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
  endtask

  // Tasks are entered 1 ns after a rising edge and return 1 ns after the next.
  task automatic write(input logic [11:0] a, input logic [31:0] d);
    start(1'b1, a);
    @(posedge clk);
    #1;
    go_idle();
    HWDATA = d;
  endtask

  task automatic read(input logic [11:0] a, input logic [31:0] e, input string n);
    start(1'b0, a);
    sb.push_back('{n, e});
    @(posedge clk);
    #1;
    go_idle();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: tracks read data phases independently of the stimulus.
  logic rd_dp;
  always @(posedge clk or negedge RSTn) begin
    if (!RSTn) rd_dp <= 1'b0;
    else       rd_dp <= HSEL && HTRANS[1] && HREADY && !HWRITE;
  end

  always @(negedge clk) begin
    exp_t e;
    if (rd_dp) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_read: got 0x%08h want no read", HRDATA);
      end else begin
        e = sb.pop_front();
        check(e.name, HRDATA, e.val);
        check({e.name, "_hresp"}, {31'd0, HRESP}, 32'd0);
      end
    end
  end

  initial begin
    #100_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    #0.1;
    RSTn = 1'b1;
    @(posedge clk);
    #1;

    // Reset state
    check("rst_irq", {31'd0, IRQ}, 32'd0);
    check("rst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
    check("rst_hrdata", HRDATA, 32'd0);
    read(A_CTRL, 32'd0, "rst_ctrl");
    read(A_LOAD, 32'd0, "rst_load");
    read(A_VALUE, 32'd0, "rst_value");
    read(A_STATUS, 32'd0, "rst_status");
    read(A_PRESCALE, 32'd0, "rst_prescale");

    // Periodic, PRESCALE=0, LOAD=4: VALUE 4,3,2,1 then flag, reload
    write(A_PRESCALE, 32'd0);
    write(A_LOAD, 32'd4);
    write(A_CTRL, 32'h3);
    read(A_VALUE, 32'd4, "per_v4");
    read(A_VALUE, 32'd3, "per_v3");
    read(A_VALUE, 32'd2, "per_v2");
    read(A_VALUE, 32'd1, "per_v1");
    read(A_STATUS, 32'd0, "per_flag_early");
    read(A_VALUE, 32'd4, "per_reload");
    read(A_STATUS, 32'd1, "per_flag");
    check("per_irq", {31'd0, IRQ}, 32'd1);
    write(A_CTRL, 32'h2);
    write(A_STATUS, 32'h1);
    read(A_STATUS, 32'd0, "per_clear");
    check("per_irq_clear", {31'd0, IRQ}, 32'd0);

    // Prescaled one-shot: ticks every 4 cycles, expiry on the 12th
    write(A_PRESCALE, 32'd3);
    write(A_LOAD, 32'd2);
    write(A_CTRL, 32'h7);
    for (int k = 0; k < 11; k++) begin
      read(A_VALUE, (k < 4) ? 32'd2 : (k < 8) ? 32'd1 : 32'd0, $sformatf("os_value_%0d", k));
    end
    read(A_STATUS, 32'd0, "os_flag_early");
    read(A_STATUS, 32'd1, "os_flag");
    read(A_CTRL, 32'h6, "os_ctrl");
    read(A_VALUE, 32'd0, "os_value_end");
    check("os_irq", {31'd0, IRQ}, 32'd1);

    // W1C on the same edge the hardware sets FLAG
    write(A_STATUS, 32'h1);
    write(A_PRESCALE, 32'd0);
    write(A_LOAD, 32'd2);
    write(A_CTRL, 32'h3);
    idle(2);
    write(A_STATUS, 32'h1);
    read(A_STATUS, 32'd1, "w1c_race");
    write(A_CTRL, 32'h2);
    write(A_STATUS, 32'h1);
    read(A_STATUS, 32'd0, "w1c_alone");
    check("w1c_irq", {31'd0, IRQ}, 32'd0);

    // Bus pipeline and register boundaries (timer stopped)
    write(A_LOAD, 32'h1234);
    read(A_LOAD, 32'h1234, "pipe_load");
    read(A_VALUE, 32'h1234, "pipe_value");
    write(A_UNMAPPED, 32'hDEAD_BEEF);
    read(A_UNMAPPED, 32'd0, "pipe_unmapped");
    write(A_VALUE, 32'd5);
    read(A_VALUE, 32'h1234, "value_ro");
    write(A_PRESCALE, 32'hABCD_EF12);
    read(A_PRESCALE, 32'h12, "prescale_mask");
    write(A_CTRL, 32'hFFFF_FFFA);
    read(A_CTRL, 32'h2, "ctrl_mask");

    // LOAD write on a tick edge wins over the decrement
    write(A_PRESCALE, 32'd0);
    write(A_LOAD, 32'd1);
    write(A_CTRL, 32'h3);
    idle(3);
    write(A_LOAD, 32'd100);
    read(A_VALUE, 32'd100, "load_race");
    read(A_VALUE, 32'd99, "load_race_next");
    check("run_irq", {31'd0, IRQ}, 32'd1);

    // Reset during a write data phase
    start(1'b1, A_LOAD);
    @(posedge clk);
    #1;
    go_idle();
    HWDATA = 32'h55;
    #2;
    RSTn = 1'b0;
    #1;
    check("rstmid_irq", {31'd0, IRQ}, 32'd0);
    check("rstmid_hrdata", HRDATA, 32'd0);
    #10;
    RSTn = 1'b1;
    @(posedge clk);
    #1;
    read(A_LOAD, 32'd0, "rstmid_load");
    read(A_VALUE, 32'd0, "rstmid_value");
    read(A_CTRL, 32'd0, "rstmid_ctrl");
    read(A_STATUS, 32'd0, "rstmid_status");
    read(A_PRESCALE, 32'd0, "rstmid_prescale");

    idle(2);
    check("sb_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
